monster_fleet_move: RTL

//  Multi-channel trajectory generator for the VGA game's monsters. Each of NUM_MONSTERS

---
 rtl/monster_fleet_move_if.sv | 35 +++
 rtl/monster_fleet_move.sv | 111 +++++++++++
 2 files changed

// File: rtl/monster_fleet_move_if.sv
// Control/status bundle for monster_fleet_move: spawn/kill/frame strobes in, per-channel
// activity, packed positions and bounce pulses out. Plain wires; no handshake or backpressure.
interface monster_fleet_move_if #(
    parameter int NUM_MONSTERS = 4,
    parameter int COORD_W      = 11,
    parameter int SPEED_W      = 10
);
    localparam int ID_W = (NUM_MONSTERS > 1) ? $clog2(NUM_MONSTERS) : 1;

    logic                            startOfFrame;
    logic                            freeze;
    logic                            spawn;
    logic [ID_W-1:0]                 spawn_id;
    logic [COORD_W-1:0]              spawn_x;
    logic [COORD_W-1:0]              spawn_y;
    logic [SPEED_W-1:0]              spawn_xspeed;
    logic [SPEED_W-1:0]              spawn_yspeed;
    logic [NUM_MONSTERS-1:0]         kill;
    logic [NUM_MONSTERS-1:0]         active;
    logic [NUM_MONSTERS*COORD_W-1:0] topLeftX;
    logic [NUM_MONSTERS*COORD_W-1:0] topLeftY;
    logic [NUM_MONSTERS-1:0]         bounce;

    modport master (
        output startOfFrame, freeze, spawn, spawn_id, spawn_x, spawn_y,
               spawn_xspeed, spawn_yspeed, kill,
        input  active, topLeftX, topLeftY, bounce
    );

    modport slave (
        input  startOfFrame, freeze, spawn, spawn_id, spawn_x, spawn_y,
               spawn_xspeed, spawn_yspeed, kill,
        output active, topLeftX, topLeftY, bounce
    );
endinterface

// File: rtl/monster_fleet_move.sv
// Per-channel fixed-point monster trajectories reflecting off a clamped bounding box.
// Position/bounce visible 1 clk after the frame strobe or spawn; no backpressure (strobes always taken).
module monster_fleet_move #(
    parameter int NUM_MONSTERS = 4,
    parameter int COORD_W      = 11,
    parameter int FRAC_BITS    = 6,
    parameter int SPEED_W      = 10,
    parameter int MIN_X        = 90,
    parameter int MAX_X        = 385,
    parameter int MIN_Y        = 90,
    parameter int MAX_Y        = 385
) (
    input  logic                 clk,
    input  logic                 resetN,
    monster_fleet_move_if.slave  bus
);
    localparam int ID_W = (NUM_MONSTERS > 1) ? $clog2(NUM_MONSTERS) : 1;
    localparam int PW   = COORD_W + FRAC_BITS + 2;

    typedef logic signed [PW-1:0] fp_t;
    typedef enum logic {IDLE, ACTIVE} state_t;
    typedef struct packed {
        logic signed [PW-1:0] pos;
        logic signed [PW-1:0] spd;
        logic                 hit;
    } axis_t;

    localparam fp_t LO_X = fp_t'(MIN_X << FRAC_BITS);
    localparam fp_t HI_X = fp_t'(MAX_X << FRAC_BITS);
    localparam fp_t LO_Y = fp_t'(MIN_Y << FRAC_BITS);
    localparam fp_t HI_Y = fp_t'(MAX_Y << FRAC_BITS);

    // Reflection only when the step would cross the bound; an exact landing reflects next frame.
    function automatic axis_t step_axis(fp_t pos, fp_t spd, fp_t lo, fp_t hi);
        fp_t   nxt;
        axis_t r;
        nxt   = pos + spd;
        r.pos = nxt;
        r.spd = spd;
        r.hit = 1'b0;
        if (spd > fp_t'(0) && nxt > hi) begin
            r.pos = hi;
            r.spd = -spd;
            r.hit = 1'b1;
        end else if (spd < fp_t'(0) && nxt < lo) begin
            r.pos = lo;
            r.spd = -spd;
            r.hit = 1'b1;
        end
        return r;
    endfunction

    function automatic fp_t load_coord(logic [COORD_W-1:0] c, fp_t lo, fp_t hi);
        fp_t v;
        v = {{(PW-COORD_W){c[COORD_W-1]}}, c};
        v = v <<< FRAC_BITS;
        if (v < lo)      v = lo;
        else if (v > hi) v = hi;
        return v;
    endfunction

    function automatic fp_t sext_speed(logic [SPEED_W-1:0] s);
        return {{(PW-SPEED_W){s[SPEED_W-1]}}, s};
    endfunction

    for (genvar i = 0; i < NUM_MONSTERS; i++) begin : g_ch
        state_t state_q;
        fp_t    px_q, py_q, sx_q, sy_q;
        logic   bounce_q;
        axis_t  ax_d, ay_d;
        logic   spawn_hit;

        assign ax_d      = step_axis(px_q, sx_q, LO_X, HI_X);
        assign ay_d      = step_axis(py_q, sy_q, LO_Y, HI_Y);
        // Ids beyond the last channel match no channel and are dropped.
        assign spawn_hit = bus.spawn && (bus.spawn_id == ID_W'(i));

        always_ff @(posedge clk or negedge resetN) begin
            if (!resetN) begin
                state_q  <= IDLE;
                px_q     <= '0;
                py_q     <= '0;
                sx_q     <= '0;
                sy_q     <= '0;
                bounce_q <= 1'b0;
            end else begin
                bounce_q <= 1'b0;
                if (bus.kill[i]) begin
                    state_q <= IDLE;
                end else if (spawn_hit) begin
                    state_q <= ACTIVE;
                    px_q    <= load_coord(bus.spawn_x, LO_X, HI_X);
                    py_q    <= load_coord(bus.spawn_y, LO_Y, HI_Y);
                    sx_q    <= sext_speed(bus.spawn_xspeed);
                    sy_q    <= sext_speed(bus.spawn_yspeed);
                end else if (state_q == ACTIVE && bus.startOfFrame && !bus.freeze) begin
                    px_q     <= ax_d.pos;
                    py_q     <= ay_d.pos;
                    sx_q     <= ax_d.spd;
                    sy_q     <= ay_d.spd;
                    bounce_q <= ax_d.hit | ay_d.hit;
                end
            end
        end

        assign bus.active[i]                        = (state_q == ACTIVE);
        assign bus.bounce[i]                        = bounce_q;
        assign bus.topLeftX[i*COORD_W +: COORD_W]   = px_q[FRAC_BITS +: COORD_W];
        assign bus.topLeftY[i*COORD_W +: COORD_W]   = py_q[FRAC_BITS +: COORD_W];
    end
endmodule
